// File: rtl/mem_pkg.sv
// Shared types and helpers for the unified memory and its DMA burst controller.
// Combinational only; no latency or backpressure of its own.
package mem_pkg;

    localparam int DEF_WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DONE
    } dma_state_t;

    // Index width for a power-of-two depth; never narrower than one bit.
    function automatic int addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dma_burst_ctrl.sv
// DMA burst sequencer: latches base and payload, presents one registered beat per cycle.
// Start to done is BURST_LEN+2 cycles; a beat held on the port stalls while stall is high.
module dma_burst_ctrl
    import mem_pkg::*;
#(
    parameter int WORD_W    = DEF_WORD_W,
    parameter int DEPTH     = 512,
    parameter int BURST_LEN = 4,
    localparam int ADDR_W   = addr_bits(DEPTH),
    localparam int BEAT_W   = addr_bits(BURST_LEN)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [ADDR_W-1:0]           addr,
    input  logic [BURST_LEN*WORD_W-1:0] data,
    input  logic                        stall,
    output logic                        we,
    output logic [ADDR_W-1:0]           waddr,
    output logic [WORD_W-1:0]           wdata,
    output logic                        busy,
    output logic                        done
);

    dma_state_t                  state;
    logic [ADDR_W-1:0]           base;
    logic [BURST_LEN*WORD_W-1:0] payload;
    logic [BEAT_W-1:0]           beat;
    logic                        hold;

    // A presented beat that lost the write port to the D-port stays on the port.
    assign hold = we && stall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            base    <= '0;
            payload <= '0;
            beat    <= '0;
            we      <= 1'b0;
            waddr   <= '0;
            wdata   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base    <= addr;
                        payload <= data;
                        beat    <= '0;
                        busy    <= 1'b1;
                        state   <= BURST;
                    end
                end
                BURST: begin
                    if (!hold) begin
                        we    <= 1'b1;
                        waddr <= base + ADDR_W'(beat);
                        wdata <= payload[beat*WORD_W +: WORD_W];
                        if (beat == BEAT_W'(BURST_LEN - 1)) begin
                            state <= DONE;
                        end else begin
                            beat <= beat + BEAT_W'(1);
                        end
                    end
                end
                DONE: begin
                    // The last beat is still on the port here; finish once it lands.
                    if (!hold) begin
                        we    <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/dma_burst_memory.sv
// Unified I/D memory with DMA burst writes; reads have 1-cycle latency, read-first.
// One write per cycle: a D-port write wins and DMA beats stall behind it.
module dma_burst_memory
    import mem_pkg::*;
#(
    parameter int    WORD_W    = DEF_WORD_W,
    parameter int    DEPTH     = 512,
    parameter int    BURST     = 4,
    parameter string INIT_FILE = ""
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_read,
    input  logic [WORD_W-1:0]       i_addr,
    output logic [WORD_W-1:0]       i_rdata,
    output logic                    i_valid,
    input  logic                    d_read,
    input  logic                    d_write,
    input  logic [WORD_W-1:0]       d_addr,
    input  logic [WORD_W-1:0]       d_wdata,
    output logic [WORD_W-1:0]       d_rdata,
    output logic                    d_valid,
    input  logic                    dma_start,
    input  logic [WORD_W-1:0]       dma_addr,
    input  logic [BURST*WORD_W-1:0] dma_data,
    output logic                    dma_busy,
    output logic                    dma_done
);

    localparam int ADDR_W = addr_bits(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];
    logic              dma_we;
    logic [ADDR_W-1:0] dma_waddr;
    logic [WORD_W-1:0] dma_wdata;

    dma_burst_ctrl #(
        .WORD_W    (WORD_W),
        .DEPTH     (DEPTH),
        .BURST_LEN (BURST)
    ) u_ctrl (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (dma_start),
        .addr    (dma_addr[ADDR_W-1:0]),
        .data    (dma_data),
        .stall   (d_write),
        .we      (dma_we),
        .waddr   (dma_waddr),
        .wdata   (dma_wdata),
        .busy    (dma_busy),
        .done    (dma_done)
    );

    // The array is never reset so its contents survive a reset, even mid-burst.
    always_ff @(posedge clk) begin
        if (d_write) begin
            mem[d_addr[ADDR_W-1:0]] <= d_wdata;
        end else if (dma_we) begin
            mem[dma_waddr] <= dma_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i_rdata <= '0;
            i_valid <= 1'b0;
            d_rdata <= '0;
            d_valid <= 1'b0;
        end else begin
            i_valid <= i_read;
            d_valid <= d_read;
            if (i_read) i_rdata <= mem[i_addr[ADDR_W-1:0]];
            if (d_read) d_rdata <= mem[d_addr[ADDR_W-1:0]];
        end
    end

    generate
        if (ADDR_W < WORD_W) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^{i_addr[WORD_W-1:ADDR_W], d_addr[WORD_W-1:ADDR_W],
                                      dma_addr[WORD_W-1:ADDR_W]};
        end
    endgenerate

endmodule
